// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multicycle sequencer for the RV32I core.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB. Instruction fetch and
// load/store share one memory port through a req/ack handshake. A wait counter
// traps a request that never gets an ack, and an unknown opcode also traps.
// Optional feature macro: RISCV_MC_INSTRET_EN adds the o_instret retire counter.
module riscv_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_opcode,
  input  logic        i_take_branch,
  input  logic        i_mem_ack,
  output logic        o_mem_req,
  output logic        o_mem_addr_sel,
  output logic        o_mem_wr_en,
  output logic        o_ir_wr_en,
  output logic        o_pc_wr_en,
  output logic [1:0]  o_pc_src,
  output logic        o_reg_wr_en,
  output logic [2:0]  o_state,
  output logic        o_trap,
  output logic [1:0]  o_trap_cause
`ifdef RISCV_MC_INSTRET_EN
  ,
  output logic [31:0] o_instret
`endif
);

  // RV32I base opcodes (same encodings as riscv_configs.v)
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // PC source select encodings
  localparam logic [1:0] SRC_PC_PC_4   = 2'd0;
  localparam logic [1:0] SRC_PC_PC_IMM = 2'd1;
  localparam logic [1:0] SRC_PC_RS_IMM = 2'd2;

  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

  // A zero timeout turns the watchdog off entirely
  localparam bit                   TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST =
    TIMEOUT_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [1:0]           trap_cause;
  logic [1:0]           next_cause;

  logic                 mem_req;
  logic                 addr_sel;
  logic                 mem_wr;
  logic                 ir_wr;
  logic                 pc_wr;
  logic [1:0]           pc_src;
  logic                 reg_wr;
  logic                 in_mem_phase;
  logic                 mem_stall;
  logic                 timeout_hit;
  logic                 opcode_legal;

  // Only the nine RV32I opcodes the datapath implements are accepted
  always_comb begin
    opcode_legal = 1'b0;
    case (i_opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: opcode_legal = 1'b1;
      default:                           opcode_legal = 1'b0;
    endcase
  end

  assign in_mem_phase = (state == S_FETCH) || (state == S_MEM);
  assign mem_stall    = in_mem_phase && !i_mem_ack;
  assign timeout_hit  = TIMEOUT_EN && mem_stall && (wait_cnt == TIMEOUT_LAST);

  // Next-state and datapath controls; ack-qualified strobes follow i_mem_ack combinationally
  always_comb begin
    next_state = state;
    next_cause = trap_cause;
    mem_req    = 1'b0;
    addr_sel   = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = SRC_PC_PC_4;
    reg_wr     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (i_mem_ack) begin
          ir_wr      = 1'b1;
          next_state = S_DECODE;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (!opcode_legal) begin
          next_state = S_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if ((i_opcode == OP_LOAD) || (i_opcode == OP_STORE)) begin
          next_state = S_MEM;
        end else if (i_opcode == OP_BRANCH) begin
          pc_wr      = 1'b1;
          pc_src     = i_take_branch ? SRC_PC_PC_IMM : SRC_PC_PC_4;
          next_state = S_FETCH;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_wr   = (i_opcode == OP_STORE);
        if (i_mem_ack) begin
          if (i_opcode == OP_STORE) begin
            pc_wr      = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end else if (timeout_hit) begin
          next_state = S_TRAP;
          next_cause = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        pc_wr      = 1'b1;
        next_state = S_FETCH;
        if (i_opcode == OP_JAL) begin
          pc_src = SRC_PC_PC_IMM;
        end else if (i_opcode == OP_JALR) begin
          pc_src = SRC_PC_RS_IMM;
        end
      end
      S_TRAP: begin
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  // State register, memory wait counter and sticky trap cause
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state      <= next_state;
      trap_cause <= next_cause;
      if (next_state != state) begin
        wait_cnt <= '0;
      end else if (mem_stall) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  // While reset is held every output reads zero, including state and trap status
  assign o_mem_req      = mem_req  & ~i_rst;
  assign o_mem_addr_sel = addr_sel & ~i_rst;
  assign o_mem_wr_en    = mem_wr   & ~i_rst;
  assign o_ir_wr_en     = ir_wr    & ~i_rst;
  assign o_pc_wr_en     = pc_wr    & ~i_rst;
  assign o_pc_src       = i_rst ? 2'd0 : pc_src;
  assign o_reg_wr_en    = reg_wr   & ~i_rst;
  assign o_state        = i_rst ? 3'd0 : state;
  assign o_trap         = (state == S_TRAP) & ~i_rst;
  assign o_trap_cause   = i_rst ? 2'b00 : trap_cause;

`ifdef RISCV_MC_INSTRET_EN
  logic [31:0] instret;

  // Retired-instruction counter: one count per PC update, wraps naturally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instret <= '0;
    end else if (pc_wr) begin
      instret <= instret + 32'd1;
    end
  end

  assign o_instret = i_rst ? 32'd0 : instret;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: table-driven bench for the multicycle sequencer, plus
// hand-written sequences for trap hold, memory timeout and reset recovery.
module tb_riscv_mc_ctrl;

  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_BEQ  = 7'h63;
  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [6:0]  i_opcode;
  logic        i_take_branch;
  logic        i_mem_ack;
  logic        o_mem_req;
  logic        o_mem_addr_sel;
  logic        o_mem_wr_en;
  logic        o_ir_wr_en;
  logic        o_pc_wr_en;
  logic [1:0]  o_pc_src;
  logic        o_reg_wr_en;
  logic [2:0]  o_state;
  logic        o_trap;
  logic [1:0]  o_trap_cause;
`ifdef RISCV_MC_INSTRET_EN
  logic [31:0] o_instret;
`endif

  int compared = 0;
  int mismatched = 0;

  riscv_mc_ctrl #(.MEM_TIMEOUT(16), .TIMEOUT_W(8)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_opcode       (i_opcode),
    .i_take_branch  (i_take_branch),
    .i_mem_ack      (i_mem_ack),
    .o_mem_req      (o_mem_req),
    .o_mem_addr_sel (o_mem_addr_sel),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_ir_wr_en     (o_ir_wr_en),
    .o_pc_wr_en     (o_pc_wr_en),
    .o_pc_src       (o_pc_src),
    .o_reg_wr_en    (o_reg_wr_en),
    .o_state        (o_state),
    .o_trap         (o_trap),
    .o_trap_cause   (o_trap_cause)
`ifdef RISCV_MC_INSTRET_EN
    ,
    .o_instret      (o_instret)
`endif
  );

  // 10 ns clock
  always #5 i_clk = ~i_clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic       tb;
    logic       ack;
    logic [13:0] expv;
  } vec_t;

  vec_t vecs[$];

  logic [13:0] act;
  assign act = {o_state, o_mem_req, o_mem_addr_sel, o_mem_wr_en, o_ir_wr_en,
                o_pc_wr_en, o_pc_src, o_reg_wr_en, o_trap, o_trap_cause};

  function automatic logic [13:0] ex(input logic [2:0] st, input logic req, input logic sel,
                                     input logic wr, input logic ir, input logic pc,
                                     input logic [1:0] src, input logic rg, input logic tr,
                                     input logic [1:0] cs);
    return {st, req, sel, wr, ir, pc, src, rg, tr, cs};
  endfunction

  task automatic addVec(input string name, input logic rst, input logic [6:0] op,
                        input logic tb, input logic ack, input logic [13:0] expv);
    vec_t v;
    v.name = name; v.rst = rst; v.op = op; v.tb = tb; v.ack = ack; v.expv = expv;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic tb,
                               input logic ack);
    i_rst         = rst;
    i_opcode      = op;
    i_take_branch = tb;
    i_mem_ack     = ack;
  endtask

  // Samples on the falling edge, then advances just past the next rising edge
  task automatic checkOutput(input string name, input logic [13:0] expv);
    @(negedge i_clk);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b required %b (state,req,sel,wr,ir,pc,src,reg,trap,cause)",
               name, act, expv);
    end
    @(posedge i_clk);
    #1;
  endtask

  // Runs one ADDI with zero-wait fetch (4 cycles) and checks each cycle
  task automatic runAddi(input string tag);
    applyStimulus(0, OP_ADDI, 0, 1); checkOutput({tag, "_f"},  ex(0,1,0,0,1,0,0,0,0,0));
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput({tag, "_d"},  ex(1,0,0,0,0,0,0,0,0,0));
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput({tag, "_e"},  ex(2,0,0,0,0,0,0,0,0,0));
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput({tag, "_wb"}, ex(4,0,0,0,0,1,0,1,0,0));
  endtask

  logic [13:0] zero_out;
  logic [13:0] fetch_wait;
  logic [13:0] trap_ill;
  logic [13:0] trap_to;

  initial begin
    zero_out   = ex(0,0,0,0,0,0,0,0,0,0);
    fetch_wait = ex(0,1,0,0,0,0,0,0,0,0);
    trap_ill   = ex(7,0,0,0,0,0,0,0,1,2'b10);
    trap_to    = ex(7,0,0,0,0,0,0,0,1,2'b01);
    applyStimulus(1, OP_ADDI, 0, 0);

    // reset, ADDI (ack ignored in DECODE)
    addVec("rst",      1, OP_ADDI, 0, 1, zero_out);
    addVec("addi_f",   0, OP_ADDI, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("addi_d",   0, OP_ADDI, 0, 1, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("addi_e",   0, OP_ADDI, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("addi_wb",  0, OP_ADDI, 0, 0, ex(4,0,0,0,0,1,0,1,0,0));
    // SW with three wait cycles in MEM
    addVec("sw_f",     0, OP_SW, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("sw_d",     0, OP_SW, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("sw_e",     0, OP_SW, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("sw_m0",    0, OP_SW, 0, 0, ex(3,1,1,1,0,0,0,0,0,0));
    addVec("sw_m1",    0, OP_SW, 0, 0, ex(3,1,1,1,0,0,0,0,0,0));
    addVec("sw_m2",    0, OP_SW, 0, 0, ex(3,1,1,1,0,0,0,0,0,0));
    addVec("sw_mack",  0, OP_SW, 0, 1, ex(3,1,1,1,0,1,0,0,0,0));
    // BEQ taken then not taken
    addVec("beqt_f",   0, OP_BEQ, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("beqt_d",   0, OP_BEQ, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("beqt_e",   0, OP_BEQ, 1, 0, ex(2,0,0,0,0,1,1,0,0,0));
    addVec("beqn_f",   0, OP_BEQ, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("beqn_d",   0, OP_BEQ, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("beqn_e",   0, OP_BEQ, 0, 0, ex(2,0,0,0,0,1,0,0,0,0));
    // LW: fetch from PC, then ALU address, then writeback
    addVec("lw_f",     0, OP_LW, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("lw_d",     0, OP_LW, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("lw_e",     0, OP_LW, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("lw_m",     0, OP_LW, 0, 1, ex(3,1,1,0,0,0,0,0,0,0));
    addVec("lw_wb",    0, OP_LW, 0, 0, ex(4,0,0,0,0,1,0,1,0,0));
    // JALR / JAL / LUI writeback PC sources
    addVec("jalr_f",   0, OP_JALR, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("jalr_d",   0, OP_JALR, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("jalr_e",   0, OP_JALR, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("jalr_wb",  0, OP_JALR, 0, 0, ex(4,0,0,0,0,1,2,1,0,0));
    addVec("jal_f",    0, OP_JAL, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("jal_d",    0, OP_JAL, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("jal_e",    0, OP_JAL, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("jal_wb",   0, OP_JAL, 0, 0, ex(4,0,0,0,0,1,1,1,0,0));
    addVec("lui_f",    0, OP_LUI, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("lui_d",    0, OP_LUI, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("lui_e",    0, OP_LUI, 1, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("lui_wb",   0, OP_LUI, 0, 0, ex(4,0,0,0,0,1,0,1,0,0));
    // reset in the middle of a store request: no retire, back to FETCH
    addVec("sw2_f",    0, OP_SW, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("sw2_d",    0, OP_SW, 0, 0, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("sw2_e",    0, OP_SW, 0, 0, ex(2,0,0,0,0,0,0,0,0,0));
    addVec("sw2_m",    0, OP_SW, 0, 0, ex(3,1,1,1,0,0,0,0,0,0));
    addVec("sw2_rst",  1, OP_SW, 0, 1, zero_out);
    addVec("post_rst", 0, OP_SW, 0, 0, fetch_wait);
    // illegal opcode into TRAP
    addVec("bad_f",    0, OP_BAD, 0, 1, ex(0,1,0,0,1,0,0,0,0,0));
    addVec("bad_d",    0, OP_BAD, 0, 1, ex(1,0,0,0,0,0,0,0,0,0));
    addVec("bad_trap", 0, OP_BAD, 0, 1, trap_ill);

    // Table section: the post_rst vector consumes one FETCH cycle (counter 0)
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].tb, vecs[i].ack);
      checkOutput(vecs[i].name, vecs[i].expv);
    end

    // TRAP is sticky for 20 cycles even with acks and legal opcodes
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, OP_ADDI, k[0], 1);
      checkOutput($sformatf("trap_hold%0d", k), trap_ill);
    end
    applyStimulus(1, OP_ADDI, 0, 1); checkOutput("trap_rst", zero_out);
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput("trap_exit", fetch_wait);

    // Timeout: that FETCH cycle above was req cycle 1; 15 more without ack trap
    for (int k = 2; k <= 16; k++) begin
      applyStimulus(0, OP_ADDI, 0, 0);
      checkOutput($sformatf("to_wait%0d", k), fetch_wait);
    end
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput("to_trap", trap_to);

    // Ack arriving in the 16th request cycle wins over the timeout
    applyStimulus(1, OP_ADDI, 0, 0); checkOutput("to_rst", zero_out);
    for (int k = 1; k <= 15; k++) begin
      applyStimulus(0, OP_ADDI, 0, 0);
      checkOutput($sformatf("ack16_wait%0d", k), fetch_wait);
    end
    applyStimulus(0, OP_ADDI, 0, 1); checkOutput("ack16_ack", ex(0,1,0,0,1,0,0,0,0,0));
    applyStimulus(0, OP_ADDI, 0, 0); checkOutput("ack16_dec", ex(1,0,0,0,0,0,0,0,0,0));

    // Timeout in MEM after the same 16 request cycles
    applyStimulus(0, OP_LW, 0, 0); checkOutput("mto_e", ex(2,0,0,0,0,0,0,0,0,0));
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, OP_LW, 0, 0);
      checkOutput($sformatf("mto_wait%0d", k), ex(3,1,1,0,0,0,0,0,0,0));
    end
    applyStimulus(0, OP_LW, 0, 1); checkOutput("mto_trap", trap_to);

`ifdef RISCV_MC_INSTRET_EN
    applyStimulus(1, OP_ADDI, 0, 0); checkOutput("ir_rst", zero_out);
    runAddi("ir_a1");
    runAddi("ir_a2");
    runAddi("ir_a3");
    @(negedge i_clk);
    compared++;
    if (o_instret !== 32'd3) begin
      mismatched++;
      $display("[TB] FAIL instret_3: got %0d required 3", o_instret);
    end
    @(posedge i_clk); #1;
    applyStimulus(0, OP_LW, 0, 1); checkOutput("ir_lw_f", ex(0,1,0,0,1,0,0,0,0,0));
    applyStimulus(0, OP_LW, 0, 0); checkOutput("ir_lw_d", ex(1,0,0,0,0,0,0,0,0,0));
    applyStimulus(0, OP_LW, 0, 0); checkOutput("ir_lw_e", ex(2,0,0,0,0,0,0,0,0,0));
    applyStimulus(0, OP_LW, 0, 0); checkOutput("ir_lw_m", ex(3,1,1,0,0,0,0,0,0,0));
    applyStimulus(1, OP_LW, 0, 1); checkOutput("ir_lw_rst", zero_out);
    applyStimulus(0, OP_LW, 0, 0);
    @(negedge i_clk);
    compared++;
    if (o_instret !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL instret_rst: got %0d required 0", o_instret);
    end
`else
    applyStimulus(1, OP_ADDI, 0, 0); checkOutput("end_rst", zero_out);
    runAddi("end_addi");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
